// File: rtl/wb_select_buffer_if.sv
// rtl/wb_select_buffer_if.sv - write-back request/result handshake bundle
interface wb_select_buffer_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 10,
    parameter int SELW  = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SELW-1:0]         sel;
    logic [1:0]              ext_mode;
    logic [NSRC*WIDTH-1:0]   src_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SELW-1:0]         out_sel;

    modport master (
        output in_valid, sel, ext_mode, src_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, sel, ext_mode, src_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/wb_select_buffer.sv
// rtl/wb_select_buffer.sv - write-back source select/extend into a 2-entry result FIFO
// Optional macro WB_CONST_SRC_EN: selector CONST_IDX yields CONST_VAL instead of its src_data slot.
module wb_select_buffer #(
    parameter int          WIDTH     = 32,
    parameter int          NSRC      = 10,
    parameter int          SELW      = 4,
    parameter int          CONST_IDX = 7,
    parameter logic [31:0] CONST_VAL = 32'd227
) (
    input  logic                clk,
    input  logic                reset,
    wb_select_buffer_if.slave   bus,
    output logic                err_sel,
    output logic [15:0]         accept_cnt
);
    localparam int HALF = WIDTH / 2;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  sel_word, new_data;
    logic [WIDTH-1:0]  head_data, tail_data;
    logic [SELW-1:0]   head_sel, tail_sel;
    logic              sel_oob;
    logic              accept, consume;
    logic              load_head_new, load_head_tail, load_tail;

    // Out-of-range selectors match no slot and so fall through to zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.sel == SELW'(k))
                sel_word = bus.src_data[k*WIDTH +: WIDTH];
        end
`ifdef WB_CONST_SRC_EN
        if (bus.sel == SELW'(CONST_IDX))
            sel_word = WIDTH'(CONST_VAL);
`endif
        sel_oob = (int'(bus.sel) >= NSRC);
    end

    always_comb begin
        new_data = sel_word;
        case (bus.ext_mode)
            2'b00: new_data = sel_word;
            2'b01: begin
                new_data = '0;
                new_data[HALF-1:0] = sel_word[HALF-1:0];
            end
            2'b10: begin
                new_data = {WIDTH{sel_word[HALF-1]}};
                new_data[HALF-1:0] = sel_word[HALF-1:0];
            end
            default: begin
                new_data = '0;
                new_data[7:0] = sel_word[7:0];
            end
        endcase
    end

    assign accept        = bus.in_valid && (state != FULL);
    assign consume       = (state != EMPTY) && bus.out_ready;
    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = head_data;
    assign bus.out_sel   = head_sel;

    always_ff @(posedge clk) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_head_new  = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt     = ONE;
                    load_head_new = 1'b1;
                end
            end
            ONE: begin
                if (accept && !consume) begin
                    state_nxt = FULL;
                    load_tail = 1'b1;
                end else if (consume && !accept) begin
                    state_nxt = EMPTY;
                end else if (accept && consume) begin
                    load_head_new = 1'b1;
                end
            end
            FULL: begin
                if (consume) begin
                    state_nxt      = ONE;
                    load_head_tail = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_data  <= '0;
            head_sel   <= '0;
            tail_data  <= '0;
            tail_sel   <= '0;
            err_sel    <= 1'b0;
            accept_cnt <= '0;
        end else begin
            if (load_head_new) begin
                head_data <= new_data;
                head_sel  <= bus.sel;
            end else if (load_head_tail) begin
                head_data <= tail_data;
                head_sel  <= tail_sel;
            end
            if (load_tail) begin
                tail_data <= new_data;
                tail_sel  <= bus.sel;
            end
            if (accept) begin
                accept_cnt <= accept_cnt + 16'd1;
                if (sel_oob)
                    err_sel <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_select_buffer.sv
// tb/tb_wb_select_buffer.sv - queue-model bench for wb_select_buffer
module tb_wb_select_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        err_sel;
    logic [15:0] accept_cnt;

    wb_select_buffer_if #(.WIDTH(32), .NSRC(10), .SELW(4)) bus ();

    wb_select_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .err_sel    (err_sel),
        .accept_cnt (accept_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  sel;
    } result_t;

    result_t     q[$];
    logic [31:0] got[$];
    int          n_got = 0;
    bit          live = 0;
    logic        m_err = 0;
    int          m_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic result_t expect_result();
        result_t     r;
        int          s;
        logic [31:0] w;
        logic [31:0] lo;
        s = int'(bus.sel);
        w = (s < 10) ? bus.src_data[s*32 +: 32] : 32'd0;
`ifdef WB_CONST_SRC_EN
        if (s == 7) w = 32'd227;
`endif
        lo = w % 32'd65536;
        case (bus.ext_mode)
            2'd0: r.data = w;
            2'd1: r.data = lo;
            2'd2: r.data = (lo >= 32'd32768) ? lo + 32'hFFFF_0000 : lo;
            default: r.data = w % 32'd256;
        endcase
        r.sel = bus.sel;
        return r;
    endfunction

    // Model: at most two results in flight, accept only when fewer than two are held.
    always @(posedge clk) begin
        bit acc, con;
        if (reset) begin
            q.delete();
            m_err = 0;
            m_cnt = 0;
            live  = 1;
        end else if (live) begin
            acc = bus.in_valid && (q.size() < 2);
            con = (q.size() > 0) && bus.out_ready;
            if (con) void'(q.pop_front());
            if (acc) begin
                q.push_back(expect_result());
                m_cnt = (m_cnt + 1) % 65536;
                if (int'(bus.sel) >= 10) m_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
            if (q.size() > 0) begin
                check("out_data", bus.out_data, q[0].data);
                check("out_sel", {28'd0, bus.out_sel}, {28'd0, q[0].sel});
            end
            check("err_sel", {31'd0, err_sel}, {31'd0, m_err});
            check("accept_cnt", {16'd0, accept_cnt}, m_cnt);
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_got++;
            if (got.size() < 16) got.push_back(bus.out_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [31:0] v);
        bus.src_data[k*32 +: 32] = v;
    endtask

    task automatic one_req(input logic [3:0] s, input logic [1:0] m);
        bus.sel      = s;
        bus.ext_mode = m;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit          seen;
        logic [31:0] exp_ext [3];
        logic [1:0]  modes   [3];
        exp_ext[0] = 32'hFFFF_8001; modes[0] = 2'b10;
        exp_ext[1] = 32'h0000_8001; modes[1] = 2'b01;
        exp_ext[2] = 32'h0000_0001; modes[2] = 2'b11;

        bus.in_valid  = 1'b1;
        bus.sel       = 4'd0;
        bus.ext_mode  = 2'b00;
        bus.out_ready = 1'b0;
        bus.src_data  = '0;
        for (int k = 0; k < 10; k++) set_src(k, 32'h1000_0000 + k);
        step();
        step();
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_accept_cnt", {16'd0, accept_cnt}, 32'd0);

        // Basic pass-through with one-cycle latency
        set_src(1, 32'hDEAD_BEEF);
        bus.out_ready = 1'b1;
        one_req(4'd1, 2'b00);
        check("basic_valid", {31'd0, bus.out_valid}, 32'd1);
        check("basic_data", bus.out_data, 32'hDEAD_BEEF);
        check("basic_sel", {28'd0, bus.out_sel}, 32'd1);
        check("basic_cnt", {16'd0, accept_cnt}, 32'd1);

        set_src(2, 32'h1234_8001);
        for (int i = 0; i < 3; i++) begin
            one_req(4'd2, modes[i]);
            check("ext_data", bus.out_data, exp_ext[i]);
        end
        step();
        step();

        // Back-pressure: A, B fill the FIFO, C stalls
        set_src(3, 32'hAAAA_0003);
        set_src(4, 32'hBBBB_0004);
        set_src(5, 32'hCCCC_0005);
        got.delete();
        bus.out_ready = 1'b0;
        bus.ext_mode  = 2'b00;
        bus.in_valid  = 1'b1;
        bus.sel = 4'd3; step();
        bus.sel = 4'd4; step();
        bus.sel = 4'd5; step();
        set_src(3, $urandom);
        set_src(4, $urandom);
        step();
        @(negedge clk);
        check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp_hold_data", bus.out_data, 32'hAAAA_0003);
        check("bp_hold_sel", {28'd0, bus.out_sel}, 32'd3);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.in_ready) seen = 1;
            step();
        end
        check("bp_c_accept_timeout", {31'd0, seen}, 32'd1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("bp_count", got.size(), 32'd3);
        if (got.size() == 3) begin
            check("bp_order_a", got[0], 32'hAAAA_0003);
            check("bp_order_b", got[1], 32'hBBBB_0004);
            check("bp_order_c", got[2], 32'hCCCC_0005);
        end

        // Out-of-range selector
        one_req(4'd12, 2'b00);
        check("oob_data", bus.out_data, 32'd0);
        check("oob_sel", {28'd0, bus.out_sel}, 32'd12);
        check("oob_err", {31'd0, err_sel}, 32'd1);
        one_req(4'd0, 2'b00);
        step();
        @(negedge clk);
        check("oob_err_sticky", {31'd0, err_sel}, 32'd1);

        // Reset while FULL discards held entries
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.sel       = 4'd1;
        step();
        step();
        @(negedge clk);
        check("full_before_rst", {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_full_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_full_err", {31'd0, err_sel}, 32'd0);
        reset = 1'b0;
        step();
        @(negedge clk);
        check("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);

        // Constant source slot
        set_src(7, 32'd5);
        one_req(4'd7, 2'b00);
`ifdef WB_CONST_SRC_EN
        check("const_data", bus.out_data, 32'd227);
`else
        check("const_data", bus.out_data, 32'd5);
`endif

        // Counter wrap under sustained streaming
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        n_got = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            bus.sel      = 4'($urandom_range(0, 15));
            bus.ext_mode = 2'($urandom_range(0, 3));
            set_src(i % 10, $urandom);
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        check("wrap_cnt", {16'd0, accept_cnt}, 32'd1);
        check("wrap_delivered", n_got, 32'd65537);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
